// File: rtl/and18_qual_pkg.sv
// rtl/and18_qual_pkg.sv - shared types and limits for the qualified 18-input AND
//
// Purpose : FSM state encoding, counter width and the legal QUAL_CYCLES range,
//           shared by and18_qual and and18_qual_fsm.
// Contents: CNT_W, QUAL_MIN, QUAL_MAX, state_t {IDLE, COUNT, QUAL}
package and18_qual_pkg;

   localparam int CNT_W    = 8;
   localparam int QUAL_MIN = 1;
   localparam int QUAL_MAX = 255;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      QUAL  = 2'd2
   } state_t;

endpackage

// File: rtl/and18_qual_fsm.sv
// rtl/and18_qual_fsm.sv - qualification FSM, run counter and rise pulse
//
// Purpose : counts consecutive enabled cycles with z0 high and declares the
//           AND qualified after QUAL_CYCLES of them.
// Ports   : ck   - rising-edge clock
//           cd   - asynchronous active-high reset
//           sp   - clock enable, freezes state and count when low
//           z0   - registered AND result from the datapath
//           zq   - high while in QUAL
//           rise - one-cycle pulse after the edge that enters QUAL
//           cnt  - current run length, saturating at QUAL_CYCLES
module and18_qual_fsm
   import and18_qual_pkg::*;
#(
   parameter int QUAL_CYCLES = 4
) (
   input  logic             ck,
   input  logic             cd,
   input  logic             sp,
   input  logic             z0,
   output logic             zq,
   output logic             rise,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] QC = CNT_W'(QUAL_CYCLES);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt_nx;
   logic [CNT_W-1:0] cnt_inc;
   logic             enter_qual;

   // cnt < QC while in COUNT, so the increment cannot overflow CNT_W
   assign cnt_inc = cnt + CNT_W'(1);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (z0) begin
               cnt_nx   = CNT_W'(1);
               state_nx = (QC == CNT_W'(1)) ? QUAL : COUNT;
            end else begin
               cnt_nx   = '0;
            end
         end
         COUNT: begin
            if (z0) begin
               cnt_nx = cnt_inc;
               if (cnt_inc == QC) begin
                  state_nx = QUAL;
               end
            end else begin
               cnt_nx   = '0;
               state_nx = IDLE;
            end
         end
         QUAL: begin
            if (z0) begin
               cnt_nx = QC;
            end else begin
               cnt_nx   = '0;
               state_nx = IDLE;
            end
         end
         default: begin
            cnt_nx   = '0;
            state_nx = IDLE;
         end
      endcase
   end

   assign enter_qual = (state_nx == QUAL) && (state != QUAL);

   always_ff @(posedge ck or posedge cd) begin
      if (cd) begin
         state <= IDLE;
         cnt   <= '0;
         zq    <= 1'b0;
         rise  <= 1'b0;
      end else begin
         // rise is not gated by sp, so it always drops on the following edge
         rise <= sp & enter_qual;
         if (sp) begin
            state <= state_nx;
            cnt   <= cnt_nx;
            zq    <= (state_nx == QUAL);
         end
      end
   end

endmodule

// File: rtl/and18_qual.sv
// rtl/and18_qual.sv - registered 18-input AND with run-length qualification
//
// Purpose : two-stage registered AND of A (AR then Z0), followed by an FSM
//           that qualifies Z0 after QUAL_CYCLES consecutive enabled highs.
// Ports   : CK   - rising-edge clock
//           CD   - asynchronous active-high reset
//           SP   - clock enable for all state
//           A    - 18 operand bits
//           Z0   - registered AND of the sampled A (2 enabled edges latency)
//           ZQ   - qualified AND
//           RISE - one-cycle pulse on ZQ 0->1
//           CNT  - current qualification count
module and18_qual
   import and18_qual_pkg::*;
#(
   parameter int QUAL_CYCLES = 4
) (
   input  logic             CK,
   input  logic             CD,
   input  logic             SP,
   input  logic [17:0]      A,
   output logic             Z0,
   output logic             ZQ,
   output logic             RISE,
   output logic [CNT_W-1:0] CNT
);

   if (QUAL_CYCLES < QUAL_MIN || QUAL_CYCLES > QUAL_MAX) begin : g_range_err
      $error("and18_qual: QUAL_CYCLES=%0d outside %0d..%0d",
             QUAL_CYCLES, QUAL_MIN, QUAL_MAX);
   end

   logic [17:0] ar;

   always_ff @(posedge CK or posedge CD) begin
      if (CD) begin
         ar <= '0;
         Z0 <= 1'b0;
      end else if (SP) begin
         ar <= A;
         Z0 <= &ar;
      end
   end

   and18_qual_fsm #(
      .QUAL_CYCLES (QUAL_CYCLES)
   ) u_fsm (
      .ck   (CK),
      .cd   (CD),
      .sp   (SP),
      .z0   (Z0),
      .zq   (ZQ),
      .rise (RISE),
      .cnt  (CNT)
   );

endmodule

// File: tb/tb_and18_qual.sv
// tb/tb_and18_qual.sv - directed self-checking bench for and18_qual
module tb_and18_qual;

   localparam logic [17:0] ONES = 18'h3FFFF;
   localparam logic [17:0] DROP = 18'h3FFFE;

   logic        CK;
   logic        CD;
   logic        SP;
   logic [17:0] A;

   logic       z0_4,   zq_4,   rise_4;
   logic [7:0] cnt_4;
   logic       z0_1,   zq_1,   rise_1;
   logic [7:0] cnt_1;
   logic       z0_255, zq_255, rise_255;
   logic [7:0] cnt_255;

   int total;
   int bad;

   and18_qual #(.QUAL_CYCLES(4)) u_q4 (
      .CK(CK), .CD(CD), .SP(SP), .A(A),
      .Z0(z0_4), .ZQ(zq_4), .RISE(rise_4), .CNT(cnt_4)
   );

   and18_qual #(.QUAL_CYCLES(1)) u_q1 (
      .CK(CK), .CD(CD), .SP(SP), .A(A),
      .Z0(z0_1), .ZQ(zq_1), .RISE(rise_1), .CNT(cnt_1)
   );

   and18_qual #(.QUAL_CYCLES(255)) u_q255 (
      .CK(CK), .CD(CD), .SP(SP), .A(A),
      .Z0(z0_255), .ZQ(zq_255), .RISE(rise_255), .CNT(cnt_255)
   );

   initial CK = 1'b0;
   always #5 CK = ~CK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CK);
      #1;
   endtask

   task automatic chk4(input string tag, input logic z0, input logic zq,
                       input logic rise, input logic [7:0] cnt);
      chk({tag, ".z0"},   {31'd0, z0_4},   {31'd0, z0});
      chk({tag, ".zq"},   {31'd0, zq_4},   {31'd0, zq});
      chk({tag, ".rise"}, {31'd0, rise_4}, {31'd0, rise});
      chk({tag, ".cnt"},  {24'd0, cnt_4},  {24'd0, cnt});
   endtask

   initial begin
      total = 0;
      bad   = 0;
      CD = 1'b0;
      SP = 1'b0;
      A  = '0;

      // asynchronous reset before any clock edge
      #1 CD = 1'b1;
      #1;
      chk4("reset_async", 1'b0, 1'b0, 1'b0, 8'd0);

      // all-ones with SP=1 while held in reset: nothing moves
      A  = ONES;
      SP = 1'b1;
      step(); step(); step();
      chk4("reset_hold", 1'b0, 1'b0, 1'b0, 8'd0);
      chk("reset_hold.zq1", {31'd0, zq_1}, 32'd0);
      CD = 1'b0;

      // A->Z0 latency of two enabled edges, then count 1..4
      step();
      chk4("lat_e1", 1'b0, 1'b0, 1'b0, 8'd0);
      step();
      chk4("lat_e2", 1'b1, 1'b0, 1'b0, 8'd0);
      step();
      chk4("cnt_e3", 1'b1, 1'b0, 1'b0, 8'd1);
      chk("q1_e3.zq",   {31'd0, zq_1},   32'd1);
      chk("q1_e3.rise", {31'd0, rise_1}, 32'd1);
      chk("q1_e3.cnt",  {24'd0, cnt_1},  32'd1);
      step();
      chk4("cnt_e4", 1'b1, 1'b0, 1'b0, 8'd2);
      chk("q1_e4.rise", {31'd0, rise_1}, 32'd0);
      chk("q1_e4.cnt",  {24'd0, cnt_1},  32'd1);
      step();
      chk4("cnt_e5", 1'b1, 1'b0, 1'b0, 8'd3);
      step();
      chk4("qual_e6", 1'b1, 1'b1, 1'b1, 8'd4);
      step();
      chk4("qual_e7", 1'b1, 1'b1, 1'b0, 8'd4);

      // QUAL_CYCLES=255: reaches 255 at edge 257 and saturates
      for (int i = 0; i < 249; i++) step();
      chk("q255_e256.cnt", {24'd0, cnt_255}, 32'd254);
      chk("q255_e256.zq",  {31'd0, zq_255},  32'd0);
      step();
      chk("q255_e257.cnt",  {24'd0, cnt_255},  32'd255);
      chk("q255_e257.zq",   {31'd0, zq_255},   32'd1);
      chk("q255_e257.rise", {31'd0, rise_255}, 32'd1);
      step(); step(); step();
      chk("q255_sat.cnt",  {24'd0, cnt_255},  32'd255);
      chk("q255_sat.rise", {31'd0, rise_255}, 32'd0);
      chk4("q4_sat", 1'b1, 1'b1, 1'b0, 8'd4);

      // one-cycle drop from QUAL, then a broken run of 3, then a fresh run
      A = DROP;
      step();
      A = ONES;
      chk4("drop_e1", 1'b1, 1'b1, 1'b0, 8'd4);
      step();
      chk4("drop_e2", 1'b0, 1'b1, 1'b0, 8'd4);
      step();
      chk4("drop_e3", 1'b1, 1'b0, 1'b0, 8'd0);
      step();
      chk4("run_e4", 1'b1, 1'b0, 1'b0, 8'd1);
      A = DROP;
      step();
      A = ONES;
      chk4("run_e5", 1'b1, 1'b0, 1'b0, 8'd2);
      step();
      chk4("run_e6", 1'b0, 1'b0, 1'b0, 8'd3);
      step();
      chk4("break_e7", 1'b1, 1'b0, 1'b0, 8'd0);
      step();
      chk4("fresh_e8", 1'b1, 1'b0, 1'b0, 8'd1);
      step(); step();
      chk4("fresh_e10", 1'b1, 1'b0, 1'b0, 8'd3);
      step();
      chk4("fresh_e11", 1'b1, 1'b1, 1'b1, 8'd4);

      // break again to reach CNT=2, then an SP=0 gap of 5 edges
      A = DROP;
      step();
      A = ONES;
      step(); step();
      chk4("pre_gap_idle", 1'b1, 1'b0, 1'b0, 8'd0);
      step(); step();
      chk4("pre_gap", 1'b1, 1'b0, 1'b0, 8'd2);
      SP = 1'b0;
      A  = '0;
      step(); step(); step(); step(); step();
      chk4("gap_hold", 1'b1, 1'b0, 1'b0, 8'd2);
      A  = ONES;
      SP = 1'b1;
      step();
      chk4("post_gap_1", 1'b1, 1'b0, 1'b0, 8'd3);
      step();
      chk4("post_gap_2", 1'b1, 1'b1, 1'b1, 8'd4);

      // RISE clears on the next edge even with SP=0
      SP = 1'b0;
      step();
      chk4("rise_sp0", 1'b1, 1'b1, 1'b0, 8'd4);
      SP = 1'b1;
      step();

      // short reset pulse between edges while in QUAL
      #3 CD = 1'b1;
      #1;
      chk4("midreset", 1'b0, 1'b0, 1'b0, 8'd0);
      CD = 1'b0;
      step();
      chk4("requal_e1", 1'b0, 1'b0, 1'b0, 8'd0);
      step();
      chk4("requal_e2", 1'b1, 1'b0, 1'b0, 8'd0);
      step(); step(); step();
      chk4("requal_e5", 1'b1, 1'b0, 1'b0, 8'd3);
      step();
      chk4("requal_e6", 1'b1, 1'b1, 1'b1, 8'd4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
